// File: rtl/ldtu_tx_scheduler.sv
// LDTU transmit scheduler: FIFO of encoder words, sync bursts, idle fill.
// Optional drop counter port drop_cnt enabled by LDTU_TX_DROP_CNT_EN.
module ldtu_tx_scheduler #(
  parameter int          DEPTH     = 8,
  parameter int          SYNC_LEN  = 16,
  parameter logic [31:0] SYNC_WORD = 32'h5A5A5A5A,
  parameter logic [31:0] IDLE_WORD = 32'hEAAAAAAA
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     fallback,
  input  logic                     load_enc,
  input  logic [31:0]              data_enc,
  input  logic                     load_fb,
  input  logic [31:0]              data_fb,
  input  logic                     sync_req,
  input  logic                     ser_ready,
  output logic [31:0]              ser_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     in_sync,
  output logic                     overflow
`ifdef LDTU_TX_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L1      = 1;
  localparam logic [AW-1:0] P1      = 1;
  localparam logic [7:0]    C_LAST  = 8'(SYNC_LEN - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fb_q;
  logic        toggle, sync_go, sync_step;
  logic        push, empty, full, pop, wr, drop;
  logic [31:0] push_data;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] mem [DEPTH];

  assign toggle    = fallback != fb_q;
  assign sync_go   = toggle | sync_req;
  assign sync_step = !sync_go && state_q == SYNC && ser_ready;
  assign push      = fb_q ? load_fb : load_enc;
  assign push_data = fb_q ? data_fb : data_enc;
  assign empty     = fifo_level == '0;
  assign full      = fifo_level == LVL_MAX;
  assign pop       = !sync_go && state_q == RUN
                     && ser_ready && !empty;
  assign wr        = !toggle && push && (!full || pop);
  assign drop      = !toggle && push && full && !pop;
  assign in_sync   = state_q == SYNC;

  // State and sync counter registers
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= SYNC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: restart bursts, count sync words
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      sync_go: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
      sync_step: begin
        if (cnt_q == C_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Source select register
  always_ff @(posedge CLK) begin
    fb_q <= fallback;
  end

  // FIFO storage
  always_ff @(posedge CLK) begin
    if (reset && wr) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (!reset || toggle) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + P1;
      if (pop) rd_ptr <= rd_ptr + P1;
      unique case ({wr, pop})
        2'b10:   fifo_level <= fifo_level + L1;
        2'b01:   fifo_level <= fifo_level - L1;
        default: ;
      endcase
    end
  end

  // Serializer word: sync, FIFO head or idle
  always_ff @(posedge CLK) begin
    if (!reset) begin
      ser_data <= IDLE_WORD;
    end else if (ser_ready) begin
      if (sync_go || state_q == SYNC)
        ser_data <= SYNC_WORD;
      else if (!empty)
        ser_data <= mem[rd_ptr];
      else
        ser_data <= IDLE_WORD;
    end
  end

  // Sticky drop flag
  always_ff @(posedge CLK) begin
    if (!reset)    overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef LDTU_TX_DROP_CNT_EN
  // Saturating drop counter, survives source toggles
  always_ff @(posedge CLK) begin
    if (!reset)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ldtu_tx_scheduler.sv
// Bench for ldtu_tx_scheduler: queue-based reference model and scoreboard.
// Directed scenarios followed by a randomized phase.
module tb_ldtu_tx_scheduler;

  localparam int          DEPTH = 8;
  localparam int          SLEN  = 16;
  localparam logic [31:0] SYNCW = 32'h5A5A5A5A;
  localparam logic [31:0] IDLEW = 32'hEAAAAAAA;

  logic        CLK;
  logic        reset;
  logic        fallback;
  logic        load_enc;
  logic [31:0] data_enc;
  logic        load_fb;
  logic [31:0] data_fb;
  logic        sync_req;
  logic        ser_ready;
  logic [31:0] ser_data;
  logic [3:0]  fifo_level;
  logic        in_sync;
  logic        overflow;
`ifdef LDTU_TX_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  ldtu_tx_scheduler #(
    .DEPTH(DEPTH), .SYNC_LEN(SLEN),
    .SYNC_WORD(SYNCW), .IDLE_WORD(IDLEW)
  ) dut (
    .CLK(CLK), .reset(reset), .fallback(fallback),
    .load_enc(load_enc), .data_enc(data_enc),
    .load_fb(load_fb), .data_fb(data_fb),
    .sync_req(sync_req), .ser_ready(ser_ready),
    .ser_data(ser_data), .fifo_level(fifo_level),
    .in_sync(in_sync), .overflow(overflow)
`ifdef LDTU_TX_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, logic [31:0] a,
                              logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endfunction

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  int          m_left = 0;
  logic        m_fb = 1'b0;
  logic        m_ovf = 1'b0;
  int          m_drops = 0;
  logic [31:0] m_last = 32'h0;
  bit          started = 1'b0;

  // Model: sync bursts are a countdown of remaining words
  always @(posedge CLK) begin
    logic        tog, go, ld;
    logic [31:0] w, d;
    started = 1'b1;
    if (!reset) begin
      mq.delete();
      m_left  = SLEN;
      m_fb    = fallback;
      m_ovf   = 1'b0;
      m_drops = 0;
      exp_q.push_back(IDLEW);
    end else begin
      tog = fallback != m_fb;
      go  = tog || sync_req;
      ld  = m_fb ? load_fb : load_enc;
      d   = m_fb ? data_fb : data_enc;
      if (ser_ready) begin
        if (go || m_left > 0) begin
          w = SYNCW;
          if (!go) m_left--;
        end else if (mq.size() > 0) begin
          w = mq.pop_front();
        end else begin
          w = IDLEW;
        end
        exp_q.push_back(w);
      end
      if (tog) begin
        mq.delete();
      end else if (ld) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(d);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (go) m_left = SLEN;
      m_fb = fallback;
    end
  end

  // Monitor: compare DUT outputs against the model each cycle
  always @(negedge CLK) begin
    if (started) begin
      if (exp_q.size() > 0) m_last = exp_q.pop_front();
      chk("ser_data", ser_data, m_last);
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("in_sync", 32'(in_sync), 32'(m_left > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef LDTU_TX_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rdy(int n, int gap);
    repeat (n) begin
      ser_ready = 1'b1;
      tick();
      ser_ready = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic push_enc(logic [31:0] d);
    load_enc = 1'b1;
    data_enc = d;
    tick();
    load_enc = 1'b0;
  endtask

  task automatic push_fb(logic [31:0] d);
    load_fb = 1'b1;
    data_fb = d;
    tick();
    load_fb = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    fallback  = 1'b0;
    load_enc  = 1'b0;
    data_enc  = '0;
    load_fb   = 1'b0;
    data_fb   = '0;
    sync_req  = 1'b0;
    ser_ready = 1'b0;
    repeat (3) tick();
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ser", ser_data, IDLEW);
    chk("rst_sync", 32'(in_sync), 1);
    reset = 1'b1;

    // Burst of 16 sync words then idle
    rdy(15, 4);
    chk("s25_mid", 32'(in_sync), 1);
    rdy(1, 4);
    chk("s25_end", 32'(in_sync), 0);
    rdy(2, 4);
    chk("s25_idle", ser_data, IDLEW);

    // A,B,C pushed during sync, fallback word ignored
    pulse_sync();
    push_enc(32'hA0A0_0001);
    push_enc(32'hB0B0_0002);
    push_enc(32'hC0C0_0003);
    push_fb(32'hDEAD_BEEF);
    rdy(20, 2);

    // Overflow: 10 pushes into depth 8
    do_reset();
    for (int i = 0; i < 10; i++) push_enc(32'h1000 + i);
    chk("s27_level", 32'(fifo_level), 8);
    chk("s27_ovf", 32'(overflow), 1);
`ifdef LDTU_TX_DROP_CNT_EN
    chk("s27_drops", 32'(drop_cnt), 2);
`endif

    // Full FIFO with push and pop together in RUN
    do_reset();
    rdy(SLEN, 2);
    for (int i = 0; i < 8; i++) push_enc(32'h2000 + i);
    load_enc  = 1'b1;
    data_enc  = 32'h2008;
    ser_ready = 1'b1;
    tick();
    load_enc  = 1'b0;
    ser_ready = 1'b0;
    chk("s30_level", 32'(fifo_level), 8);
    chk("s30_ovf", 32'(overflow), 0);
    chk("s30_head", ser_data, 32'h2000);
    rdy(9, 2);

    // Fallback toggle with 5 queued words
    for (int i = 0; i < 5; i++) push_enc(32'h3000 + i);
    fallback  = 1'b1;
    load_enc  = 1'b1;
    data_enc  = 32'h3FFF;
    ser_ready = 1'b1;
    tick();
    load_enc  = 1'b0;
    ser_ready = 1'b0;
    chk("s28_level", 32'(fifo_level), 0);
    chk("s28_ser", ser_data, SYNCW);
    chk("s28_sync", 32'(in_sync), 1);
    rdy(SLEN, 2);
    push_fb(32'h4000_0001);
    push_fb(32'h4000_0002);
    rdy(4, 2);

    // sync_req after word 10 restarts the burst
    pulse_sync();
    rdy(10, 2);
    pulse_sync();
    rdy(15, 2);
    chk("s29_mid", 32'(in_sync), 1);
    rdy(1, 2);
    chk("s29_end", 32'(in_sync), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(299) != 0);
      if ($urandom_range(63) == 0) fallback = ~fallback;
      load_enc  = $urandom_range(1);
      data_enc  = $urandom;
      load_fb   = $urandom_range(1);
      data_fb   = $urandom;
      ser_ready = ($urandom_range(2) == 0);
      sync_req  = ($urandom_range(99) == 0);
      tick();
    end
    reset     = 1'b1;
    load_enc  = 1'b0;
    load_fb   = 1'b0;
    ser_ready = 1'b0;
    sync_req  = 1'b0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
